fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 125 ++++++++++++
 tb/tb_fetch_unit.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one instruction-memory request at a time, holds the fetched word
// until decode accepts it, and squashes in-flight fetches on redirect. Optional macro: FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
   parameter logic [31:0] PC_STEP  = 32'd4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        done,
   input  logic [31:0] pc_cur,
   output logic [31:0] pc_next,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_target,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        inst_ready,
   output logic        fetch_fault
);

   typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

   state_t      state_q, state_d;
   logic        squash_q, squash_d;
   logic        fault_q, fault_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] inst_q, inst_pc_q;
   logic        capture;
   logic [31:0] target;
   logic        misaligned;
   logic        redir;
   logic        blocked;

`ifdef FETCH_MISALIGN_TRAP_EN
   assign target     = redirect_target;
   assign misaligned = redirect & (redirect_target[1:0] != 2'b00);
`else
   logic unused_tgt_bits;
   assign unused_tgt_bits = ^redirect_target[1:0];
   assign target          = {redirect_target[31:2], 2'b00};
   assign misaligned      = 1'b0;
`endif

   // A trapped redirect is not a redirect at all, and nothing moves the PC while in reset.
   assign redir   = redirect & rst & ~misaligned;
   assign blocked = done | fault_q | misaligned;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d  = state_q;
      squash_d = squash_q;
      addr_d   = addr_q;
      capture  = 1'b0;
      fault_d  = fault_q | misaligned;
      pc_next  = redir ? target : pc_cur;
      case (state_q)
         IDLE: begin
            if (!redir && !blocked) begin
               state_d = FETCH;
               addr_d  = pc_cur;
            end
         end
         FETCH: begin
            if (imem_ack) begin
               squash_d = 1'b0;
               if (squash_q || redir) begin
                  // pc_next already carries the redirect target (this cycle's or the latched one).
                  if (blocked) state_d = IDLE;
                  else         addr_d  = pc_next;
               end else begin
                  pc_next = addr_q + PC_STEP;
                  capture = 1'b1;
                  state_d = HOLD;
               end
            end else if (redir) begin
               squash_d = 1'b1;
            end
         end
         HOLD: begin
            if (redir || inst_ready) begin
               if (blocked) begin
                  state_d = IDLE;
               end else begin
                  state_d = FETCH;
                  addr_d  = pc_next;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         squash_q  <= 1'b0;
         fault_q   <= 1'b0;
         addr_q    <= '0;
         inst_q    <= '0;
         inst_pc_q <= RESET_PC;
      end else begin
         state_q  <= state_d;
         squash_q <= squash_d;
         fault_q  <= fault_d;
         addr_q   <= addr_d;
         if (capture) begin
            inst_q    <= imem_rdata;
            inst_pc_q <= addr_q;
         end
      end
   end

   assign imem_req    = (state_q == FETCH);
   assign imem_addr   = addr_q;
   assign inst_valid  = (state_q == HOLD);
   assign inst        = inst_q;
   assign inst_pc     = inst_pc_q;
   assign fetch_fault = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: models the external PC register, scripts memory responses and
// scoreboards delivered instructions against expected {word, address} pairs.
module tb_fetch_unit;

   localparam logic [31:0] TB_RESET_PC = 32'h0000_1000;

   typedef struct packed {
      logic [31:0] data;
      logic [31:0] pc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        done;
   logic [31:0] pc_cur;
   logic [31:0] pc_next;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_target;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_ready;
   logic        fetch_fault;

   logic [31:0] pc_rst_val;
   exp_t        sb[$];
   int          n_pass  = 0;
   int          n_total = 0;

   fetch_unit #(.PC_STEP(32'd4), .RESET_PC(TB_RESET_PC)) dut (
      .clk(clk), .rst(rst), .done(done), .pc_cur(pc_cur), .pc_next(pc_next),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .redirect(redirect), .redirect_target(redirect_target), .inst_valid(inst_valid),
      .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready), .fetch_fault(fetch_fault)
   );

   always #5 clk = ~clk;

   // External PC register fed by pc_next.
   always @(posedge clk or negedge rst) begin
      if (!rst) pc_cur <= pc_rst_val;
      else      pc_cur <= pc_next;
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic [31:0] pc0);
      imem_ack = 1'b0; redirect = 1'b0; inst_ready = 1'b0; done = 1'b0;
      pc_rst_val = pc0;
      rst = 1'b0;
      cyc(); cyc();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      exp_t e;
      imem_ack = 1'b0; imem_rdata = '0; redirect = 1'b1; redirect_target = 32'h0000_0500;
      inst_ready = 1'b0; done = 1'b0; pc_rst_val = 32'h0000_0000;
      rst = 1'b0;
      cyc(); cyc(); #1;
      n_total++; if (imem_req !== 1'b0) $display("FAIL rst_req got=%b exp=0", imem_req); else n_pass++;
      n_total++; if (imem_addr !== 32'h0) $display("FAIL rst_addr got=%h exp=0", imem_addr); else n_pass++;
      n_total++; if (inst_valid !== 1'b0) $display("FAIL rst_valid got=%b exp=0", inst_valid); else n_pass++;
      n_total++; if (inst !== 32'h0) $display("FAIL rst_inst got=%h exp=0", inst); else n_pass++;
      n_total++; if (inst_pc !== TB_RESET_PC) $display("FAIL rst_inst_pc got=%h exp=%h", inst_pc, TB_RESET_PC); else n_pass++;
      n_total++; if (fetch_fault !== 1'b0) $display("FAIL rst_fault got=%b exp=0", fetch_fault); else n_pass++;
      n_total++; if (pc_next !== 32'h0) $display("FAIL rst_pc_next got=%h exp=0", pc_next); else n_pass++;
      redirect = 1'b0;
      e = '0;
      sb.delete();
   endtask

   task automatic test_basic();
      exp_t e;
      rst = 1'b1;
      cyc();
      n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("FAIL basic_issue req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr); else n_pass++;
      cyc(); cyc();
      n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("FAIL basic_stable req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr); else n_pass++;
      imem_ack = 1'b1; imem_rdata = 32'h2008_0005; inst_ready = 1'b1;
      sb.push_back('{data: 32'h2008_0005, pc: 32'h0});
      #1;
      n_total++; if (pc_next !== 32'h4) $display("FAIL basic_pc_next got=%h exp=4", pc_next); else n_pass++;
      cyc();
      imem_ack = 1'b0;
      e = sb.pop_front();
      n_total++; if (inst_valid !== 1'b1 || inst !== e.data || inst_pc !== e.pc)
         $display("FAIL basic_deliver valid=%b inst=%h pc=%h exp 1 %h %h", inst_valid, inst, inst_pc, e.data, e.pc); else n_pass++;
      cyc();
      inst_ready = 1'b0;
      n_total++; if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h4)
         $display("FAIL basic_next valid=%b req=%b addr=%h exp 0 1 4", inst_valid, imem_req, imem_addr); else n_pass++;
   endtask

   task automatic test_hold_stall();
      exp_t e;
      imem_ack = 1'b1; imem_rdata = 32'hAAAA_0001;
      sb.push_back('{data: 32'hAAAA_0001, pc: 32'h4});
      #1;
      n_total++; if (pc_next !== 32'h8) $display("FAIL stall_pc_next got=%h exp=8", pc_next); else n_pass++;
      cyc();
      imem_ack = 1'b0;
      e = sb[0];
      for (int i = 0; i < 5; i++) begin
         n_total++; if (inst_valid !== 1'b1 || inst !== e.data || inst_pc !== e.pc || imem_req !== 1'b0 || pc_next !== 32'h8)
            $display("FAIL stall_hold[%0d] valid=%b inst=%h pc=%h req=%b pc_next=%h exp 1 %h %h 0 8", i, inst_valid, inst, inst_pc, imem_req, pc_next, e.data, e.pc);
         else n_pass++;
         cyc();
      end
      inst_ready = 1'b1;
      e = sb.pop_front();
      n_total++; if (inst !== e.data || inst_pc !== e.pc) $display("FAIL stall_accept inst=%h pc=%h exp %h %h", inst, inst_pc, e.data, e.pc); else n_pass++;
      cyc();
      inst_ready = 1'b0;
      n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) $display("FAIL stall_next req=%b addr=%h exp 1 8", imem_req, imem_addr); else n_pass++;
   endtask

   task automatic test_redirect_with_ack();
      exp_t e;
      redirect = 1'b1; redirect_target = 32'h0000_0040; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      #1;
      n_total++; if (pc_next !== 32'h40) $display("FAIL rdack_pc_next got=%h exp=40", pc_next); else n_pass++;
      cyc();
      redirect = 1'b0; imem_ack = 1'b0;
      n_total++; if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40)
         $display("FAIL rdack_squash valid=%b req=%b addr=%h exp 0 1 40", inst_valid, imem_req, imem_addr); else n_pass++;
      cyc();
      n_total++; if (inst_valid !== 1'b0) $display("FAIL rdack_discard valid=%b exp=0", inst_valid); else n_pass++;
      imem_ack = 1'b1; imem_rdata = 32'h1111_0040;
      sb.push_back('{data: 32'h1111_0040, pc: 32'h40});
      #1;
      n_total++; if (pc_next !== 32'h44) $display("FAIL rdack_pc_next2 got=%h exp=44", pc_next); else n_pass++;
      cyc();
      imem_ack = 1'b0; inst_ready = 1'b1;
      e = sb.pop_front();
      n_total++; if (inst_valid !== 1'b1 || inst !== e.data || inst_pc !== e.pc)
         $display("FAIL rdack_deliver valid=%b inst=%h pc=%h exp 1 %h %h", inst_valid, inst, inst_pc, e.data, e.pc); else n_pass++;
      cyc();
      inst_ready = 1'b0;
   endtask

   task automatic test_redirect_before_ack();
      exp_t e;
      redirect = 1'b1; redirect_target = 32'h0000_0080;
      #1;
      n_total++; if (pc_next !== 32'h80) $display("FAIL rdpre_pc_next got=%h exp=80", pc_next); else n_pass++;
      cyc();
      redirect = 1'b0;
      n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h44) $display("FAIL rdpre_stable req=%b addr=%h exp 1 44", imem_req, imem_addr); else n_pass++;
      cyc();
      imem_ack = 1'b1; imem_rdata = 32'hBAD0_0044;
      #1;
      n_total++; if (pc_next !== 32'h80) $display("FAIL rdpre_ack_pc_next got=%h exp=80", pc_next); else n_pass++;
      cyc();
      imem_ack = 1'b0;
      n_total++; if (inst_valid !== 1'b0 || imem_addr !== 32'h80) $display("FAIL rdpre_reissue valid=%b addr=%h exp 0 80", inst_valid, imem_addr); else n_pass++;
      imem_ack = 1'b1; imem_rdata = 32'h2222_0080;
      sb.push_back('{data: 32'h2222_0080, pc: 32'h80});
      cyc();
      imem_ack = 1'b0;
      e = sb[0];
      n_total++; if (inst_valid !== 1'b1 || inst !== e.data || inst_pc !== e.pc)
         $display("FAIL rdpre_deliver valid=%b inst=%h pc=%h exp 1 %h %h", inst_valid, inst, inst_pc, e.data, e.pc); else n_pass++;
   endtask

   task automatic test_redirect_hold();
      exp_t e;
      redirect = 1'b1; redirect_target = 32'h0000_0200;
      #1;
      n_total++; if (pc_next !== 32'h200) $display("FAIL rdhold_pc_next got=%h exp=200", pc_next); else n_pass++;
      e = sb.pop_front();
      cyc();
      redirect = 1'b0;
      n_total++; if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200)
         $display("FAIL rdhold_flush valid=%b req=%b addr=%h exp 0 1 200 (flushed %h)", inst_valid, imem_req, imem_addr, e.data); else n_pass++;
   endtask

   task automatic test_done();
      exp_t e;
      done = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h3333_0200;
      sb.push_back('{data: 32'h3333_0200, pc: 32'h200});
      cyc();
      imem_ack = 1'b0; inst_ready = 1'b1;
      e = sb.pop_front();
      n_total++; if (inst_valid !== 1'b1 || inst !== e.data || inst_pc !== e.pc)
         $display("FAIL done_deliver valid=%b inst=%h pc=%h exp 1 %h %h", inst_valid, inst, inst_pc, e.data, e.pc); else n_pass++;
      cyc();
      inst_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_total++; if (imem_req !== 1'b0 || inst_valid !== 1'b0) $display("FAIL done_idle[%0d] req=%b valid=%b exp 0 0", i, imem_req, inst_valid); else n_pass++;
         cyc();
      end
      done = 1'b0;
      cyc();
      n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h204) $display("FAIL done_resume req=%b addr=%h exp 1 204", imem_req, imem_addr); else n_pass++;
   endtask

   task automatic test_wrap();
      exp_t e;
      do_reset(32'hFFFF_FFFC);
      cyc();
      n_total++; if (imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_issue addr=%h exp fffffffc", imem_addr); else n_pass++;
      imem_ack = 1'b1; imem_rdata = 32'h4444_FFFC;
      sb.push_back('{data: 32'h4444_FFFC, pc: 32'hFFFF_FFFC});
      #1;
      n_total++; if (pc_next !== 32'h0 || fetch_fault !== 1'b0) $display("FAIL wrap_pc_next got=%h fault=%b exp 0 0", pc_next, fetch_fault); else n_pass++;
      cyc();
      imem_ack = 1'b0; inst_ready = 1'b1;
      e = sb.pop_front();
      n_total++; if (inst !== e.data || inst_pc !== e.pc) $display("FAIL wrap_deliver inst=%h pc=%h exp %h %h", inst, inst_pc, e.data, e.pc); else n_pass++;
      cyc();
      inst_ready = 1'b0;
      n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("FAIL wrap_next req=%b addr=%h exp 1 0", imem_req, imem_addr); else n_pass++;
   endtask

   task automatic test_misalign();
      exp_t e;
      redirect = 1'b1; redirect_target = 32'h0000_0042;
      #1;
`ifdef FETCH_MISALIGN_TRAP_EN
      n_total++; if (pc_next !== 32'h0) $display("FAIL mis_pc_next got=%h exp=0", pc_next); else n_pass++;
      cyc();
      redirect = 1'b0;
      n_total++; if (fetch_fault !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 32'h0)
         $display("FAIL mis_fault fault=%b req=%b addr=%h exp 1 1 0", fetch_fault, imem_req, imem_addr); else n_pass++;
      imem_ack = 1'b1; imem_rdata = 32'h5555_0000;
      sb.push_back('{data: 32'h5555_0000, pc: 32'h0});
      cyc();
      imem_ack = 1'b0; inst_ready = 1'b1;
      e = sb.pop_front();
      n_total++; if (inst_valid !== 1'b1 || inst !== e.data || inst_pc !== e.pc)
         $display("FAIL mis_deliver valid=%b inst=%h pc=%h exp 1 %h %h", inst_valid, inst, inst_pc, e.data, e.pc); else n_pass++;
      cyc();
      inst_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_total++; if (imem_req !== 1'b0 || fetch_fault !== 1'b1) $display("FAIL mis_blocked[%0d] req=%b fault=%b exp 0 1", i, imem_req, fetch_fault); else n_pass++;
         cyc();
      end
`else
      n_total++; if (pc_next !== 32'h40) $display("FAIL mis_pc_next got=%h exp=40", pc_next); else n_pass++;
      cyc();
      redirect = 1'b0;
      imem_ack = 1'b1; imem_rdata = 32'hBAD0_0000;
      cyc();
      imem_ack = 1'b0;
      n_total++; if (imem_addr !== 32'h40 || inst_valid !== 1'b0 || fetch_fault !== 1'b0)
         $display("FAIL mis_forced addr=%h valid=%b fault=%b exp 40 0 0", imem_addr, inst_valid, fetch_fault); else n_pass++;
      e = '0;
`endif
   endtask

   task automatic test_reset_mid_fetch();
      do_reset(32'h0000_0300);
      cyc();
      n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h300 || fetch_fault !== 1'b0)
         $display("FAIL rmid_issue req=%b addr=%h fault=%b exp 1 300 0", imem_req, imem_addr, fetch_fault); else n_pass++;
      #2 rst = 1'b0;
      #1;
      n_total++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) $display("FAIL rmid_async req=%b addr=%h exp 0 0", imem_req, imem_addr); else n_pass++;
      imem_ack = 1'b1; imem_rdata = 32'hBAD0_0300;
      cyc();
      rst = 1'b1;
      cyc();
      imem_ack = 1'b0;
      n_total++; if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h300)
         $display("FAIL rmid_ignore valid=%b req=%b addr=%h exp 0 1 300", inst_valid, imem_req, imem_addr); else n_pass++;
      cyc();
      n_total++; if (inst_valid !== 1'b0) $display("FAIL rmid_no_deliver valid=%b exp=0", inst_valid); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_hold_stall();
      test_redirect_with_ack();
      test_redirect_before_ack();
      test_redirect_hold();
      test_done();
      test_wrap();
      test_misalign();
      test_reset_mid_fetch();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
